// File: rtl/seq_det_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | seq_det_pkg : state encoding and default widths for the frame ctrl  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package seq_det_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_CNT_W  = 8;

    localparam int ST_W = 3;
    localparam logic [ST_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [ST_W-1:0] ST_SHIFT = 3'd1;
    localparam logic [ST_W-1:0] ST_DRAIN = 3'd2;
    localparam logic [ST_W-1:0] ST_DONE  = 3'd3;
    localparam logic [ST_W-1:0] ST_ABORT = 3'd4;

endpackage
`default_nettype wire

// File: rtl/seq_det_piso.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | seq_det_piso : parallel-load shift register, MSB first, bit index   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module seq_det_piso
    import seq_det_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              shift_i,
    output logic              bit_o,
    output logic              last_bit_o
);

    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

    logic [DATA_W-1:0] sr_q;
    logic [IDX_W-1:0]  idx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q  <= '0;
            idx_q <= '0;
        end else if (load_i) begin
            sr_q  <= data_i;
            idx_q <= '0;
        end else if (shift_i) begin
            sr_q  <= sr_q << 1;
            idx_q <= idx_q + IDX_W'(1);
        end
    end

    assign bit_o      = sr_q[DATA_W-1];
    assign last_bit_o = (idx_q == IDX_LAST);

endmodule
`default_nettype wire

// File: rtl/seq_det_frame_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | seq_det_frame_ctrl : feeds words bit-serially to the 110100 detector|
// | and reports per-frame match count or underrun error.   Rev 1.0      |
// +--------------------------------------------------------------------+
module seq_det_frame_ctrl
    import seq_det_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              det_rst,
    output logic              det_data,
    input  logic              det_found,
    output logic              cnt_valid,
    output logic [CNT_W-1:0]  cnt_value,
    output logic              cnt_ovf,
    output logic              frame_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [ST_W-1:0]  state_q, state_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] rep_cnt_q;
    logic             rep_ovf_q;
    logic             piso_bit;
    logic             piso_last;
    logic             accept;

    seq_det_piso #(
        .DATA_W (DATA_W)
    ) u_piso (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (accept),
        .data_i     (in_data),
        .shift_i    (state_q == ST_SHIFT),
        .bit_o      (piso_bit),
        .last_bit_o (piso_last)
    );

    // Ready only decodes registered state; gated by rst_n so nothing is taken during reset.
    assign in_ready = rst_n && ((state_q == ST_IDLE) ||
                                ((state_q == ST_SHIFT) && piso_last && !last_q));
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        if (((state_q == ST_SHIFT) || (state_q == ST_DRAIN)) && det_found) begin
            if (count_q == CNT_MAX) begin
                ovf_d = 1'b1;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_SHIFT;
                    last_d  = in_last;
                    count_d = '0;
                    ovf_d   = 1'b0;
                end
            end
            ST_SHIFT: begin
                if (piso_last) begin
                    if (last_q) begin
                        state_d = ST_DRAIN;
                    end else if (accept) begin
                        last_d = in_last;
                    end else begin
                        state_d = ST_ABORT;
                    end
                end
            end
            ST_DRAIN: state_d = ST_DONE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            last_q    <= 1'b0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            rep_cnt_q <= '0;
            rep_ovf_q <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            // Latch the result including the final found pulse seen in DRAIN.
            if (state_q == ST_DRAIN) begin
                rep_cnt_q <= count_d;
                rep_ovf_q <= ovf_d;
            end
        end
    end

    assign det_rst   = !((state_q == ST_SHIFT) || (state_q == ST_DRAIN));
    assign det_data  = (state_q == ST_SHIFT) && piso_bit;
    assign cnt_valid = (state_q == ST_DONE);
    assign frame_err = (state_q == ST_ABORT);
    assign cnt_value = rep_cnt_q;
    assign cnt_ovf   = rep_ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_det_frame_ctrl.sv
`default_nettype none
// Bench: two controllers (CNT_W=8 and CNT_W=2) share one stimulus stream, each with
// its own behavioural 110100 detector; per-cycle expectations come from frame timing rules.
module tb_seq_det_frame_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       in_valid;
    logic       in_last;
    logic [7:0] in_data;
    logic [1:0] in_ready, det_rst, det_data, det_found, cnt_valid, cnt_ovf, frame_err;
    logic [7:0] cnt_value_a;
    logic [1:0] cnt_value_b;

    seq_det_frame_ctrl #(.DATA_W(8), .CNT_W(8)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[0]),
        .in_data(in_data), .in_last(in_last), .det_rst(det_rst[0]),
        .det_data(det_data[0]), .det_found(det_found[0]), .cnt_valid(cnt_valid[0]),
        .cnt_value(cnt_value_a), .cnt_ovf(cnt_ovf[0]), .frame_err(frame_err[0])
    );

    seq_det_frame_ctrl #(.DATA_W(8), .CNT_W(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[1]),
        .in_data(in_data), .in_last(in_last), .det_rst(det_rst[1]),
        .det_data(det_data[1]), .det_found(det_found[1]), .cnt_valid(cnt_valid[1]),
        .cnt_value(cnt_value_b), .cnt_ovf(cnt_ovf[1]), .frame_err(frame_err[1])
    );

    // Behavioural serial detector: overlapping 110100, registered found, sync reset.
    logic [5:0] hist [2];
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (det_rst[i]) begin
                hist[i]      <= 6'd0;
                det_found[i] <= 1'b0;
            end else begin
                hist[i]      <= {hist[i][4:0], det_data[i]};
                det_found[i] <= ({hist[i][4:0], det_data[i]} == 6'b110100);
            end
        end
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Expected per-cycle outputs (shared by both instances except counts).
    logic       exp_chk = 1'b0;
    logic       exp_rst, exp_data, exp_ready, exp_valid, exp_err;
    logic [7:0] exp_cnt_a;
    logic [1:0] exp_cnt_b;
    logic       exp_ovf_a, exp_ovf_b;

    always @(negedge clk) begin
        if (exp_chk) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("det_rst[%0d]", i),   det_rst[i],   exp_rst);
                chk($sformatf("det_data[%0d]", i),  det_data[i],  exp_data);
                chk($sformatf("in_ready[%0d]", i),  in_ready[i],  exp_ready);
                chk($sformatf("cnt_valid[%0d]", i), cnt_valid[i], exp_valid);
                chk($sformatf("frame_err[%0d]", i), frame_err[i], exp_err);
            end
            chk("cnt_value_a", cnt_value_a, exp_cnt_a);
            chk("cnt_ovf_a",   cnt_ovf[0],  exp_ovf_a);
            chk("cnt_value_b", cnt_value_b, exp_cnt_b);
            chk("cnt_ovf_b",   cnt_ovf[1],  exp_ovf_b);
        end
    end

    // Reference: count overlapping 110100 occurrences in the MSB-first frame bit string.
    function automatic int count_matches(input logic [7:0] w[$]);
        int bits[$];
        int c = 0;
        foreach (w[k]) for (int j = 7; j >= 0; j--) bits.push_back(int'(w[k][j]));
        for (int i = 0; i + 5 < bits.size(); i++)
            if (bits[i] == 1 && bits[i+1] == 1 && bits[i+2] == 0 &&
                bits[i+3] == 1 && bits[i+4] == 0 && bits[i+5] == 0) c++;
        return c;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_exp(input logic r, input logic d, input logic rdy,
                           input logic v, input logic e);
        exp_rst = r; exp_data = d; exp_ready = rdy; exp_valid = v; exp_err = e;
    endtask

    task automatic junk_inputs();
        in_valid = 1'($urandom_range(0, 1));
        in_data  = 8'($urandom);
        in_last  = 1'($urandom_range(0, 1));
    endtask

    // abort_k: word after which valid is withheld (-1 none); rst_bit: frame bit index
    // at which rst_n pulses low for one cycle (-1 none).
    task automatic send_frame(input logic [7:0] w[$], input int abort_k,
                              input int rst_bit, input int gap);
        int n = w.size();
        int m = count_matches(w);
        bit boundary;
        repeat (gap) begin
            next_cycle();
            in_valid = 1'b0; in_data = 8'($urandom); in_last = 1'($urandom_range(0, 1));
            set_exp(1, 0, 1, 0, 0);
        end
        next_cycle();
        in_valid = 1'b1; in_data = w[0]; in_last = (n == 1);
        set_exp(1, 0, 1, 0, 0);
        for (int k = 0; k < n; k++) begin
            for (int j = 0; j < 8; j++) begin
                next_cycle();
                if (k * 8 + j == rst_bit) begin
                    rst_n = 1'b0; in_valid = 1'b0;
                    set_exp(1, 0, 0, 0, 0);
                    exp_cnt_a = '0; exp_cnt_b = '0; exp_ovf_a = 0; exp_ovf_b = 0;
                    next_cycle();
                    rst_n = 1'b1; in_valid = 1'b0;
                    set_exp(1, 0, 1, 0, 0);
                    return;
                end
                boundary = (j == 7) && (k != n - 1);
                set_exp(0, w[k][7-j], boundary, 0, 0);
                if (boundary) begin
                    if (k == abort_k) begin
                        in_valid = 1'b0;
                        next_cycle();
                        junk_inputs();
                        set_exp(1, 0, 0, 0, 1);
                        return;
                    end
                    in_valid = 1'b1; in_data = w[k+1]; in_last = (k + 1 == n - 1);
                end else begin
                    junk_inputs();
                end
            end
        end
        next_cycle();
        junk_inputs();
        set_exp(0, 0, 0, 0, 0);
        next_cycle();
        junk_inputs();
        set_exp(1, 0, 0, 1, 0);
        exp_cnt_a = (m > 255) ? 8'd255 : 8'(m);
        exp_ovf_a = (m > 255);
        exp_cnt_b = (m > 3) ? 2'd3 : 2'(m);
        exp_ovf_b = (m > 3);
    endtask

    logic [7:0] q[$];
    logic [7:0] fav [7] = '{8'hD0, 8'hD3, 8'h40, 8'h34, 8'h1A, 8'h68, 8'hB4};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        set_exp(1, 0, 0, 0, 0);
        exp_cnt_a = '0; exp_cnt_b = '0; exp_ovf_a = 0; exp_ovf_b = 0;
        exp_chk = 1'b1;
        repeat (3) next_cycle();
        rst_n = 1'b1;
        set_exp(1, 0, 1, 0, 0);

        // 1: single word D0
        q = '{8'hD0};
        chk("model_d0", count_matches(q), 1);
        send_frame(q, -1, -1, 2);
        @(negedge clk);
        chk("t1_cnt", cnt_value_a, 1); chk("t1_ovf", cnt_ovf[0], 0);

        // 2: match across the word boundary
        q = '{8'hD3, 8'h40};
        chk("model_d3_40", count_matches(q), 2);
        send_frame(q, -1, -1, 0);
        @(negedge clk);
        chk("t2_cnt", cnt_value_a, 2);

        // 3: empty-result frame still reports
        q = '{8'h00};
        send_frame(q, -1, -1, 1);
        @(negedge clk);
        chk("t3_cnt", cnt_value_a, 0); chk("t3_valid", cnt_valid[0], 1);

        // 4: underrun at the first word boundary
        q = '{8'hD0, 8'hD0};
        send_frame(q, 0, -1, 1);
        @(negedge clk);
        chk("t4_err", frame_err[0], 1); chk("t4_cnt_held", cnt_value_a, 0);

        // 5: four D0 words saturate the 2-bit counter
        q = '{8'hD0, 8'hD0, 8'hD0, 8'hD0};
        chk("model_4xd0", count_matches(q), 4);
        send_frame(q, -1, -1, 1);
        @(negedge clk);
        chk("t5_cnt_b", cnt_value_b, 3); chk("t5_ovf_b", cnt_ovf[1], 1);
        chk("t5_cnt_a", cnt_value_a, 4); chk("t5_ovf_a", cnt_ovf[0], 0);

        // 6: reset pulse mid-SHIFT, then a clean frame
        q = '{8'hD0, 8'hD0};
        send_frame(q, -1, 3, 1);
        q = '{8'hD0};
        send_frame(q, -1, -1, 0);
        @(negedge clk);
        chk("t6_cnt", cnt_value_a, 1); chk("t6_ovf_b", cnt_ovf[1], 0);

        // Randomized frames
        for (int f = 0; f < 200; f++) begin
            int n = $urandom_range(1, 6);
            int ab = -1;
            int rb = -1;
            q.delete();
            for (int k = 0; k < n; k++)
                q.push_back(($urandom_range(0, 1) != 0) ? fav[$urandom_range(0, 6)] : 8'($urandom));
            if (n > 1 && $urandom_range(0, 7) == 0) ab = $urandom_range(0, n - 2);
            else if ($urandom_range(0, 15) == 0) rb = $urandom_range(0, n * 8 - 1);
            send_frame(q, ab, rb, $urandom_range(0, 3));
        end

        next_cycle();
        in_valid = 1'b0;
        set_exp(1, 0, 1, 0, 0);
        repeat (2) next_cycle();
        exp_chk = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
